// File: rtl/cmp_result_tracker_if.sv
// Handshake and result bus between the comparator-side producer and the
// result tracker. The producer presents one-hot comparator flags under
// in_valid/in_ready; the tracker returns its counts and stability status.
interface cmp_result_tracker_if #(
  parameter int CNT_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic             a_eq_b;
  logic             a_ls_b;
  logic             a_gt_b;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] ls_cnt;
  logic [CNT_W-1:0] gt_cnt;
  logic             stable;
  logic [1:0]       stable_res;
  logic             err;

  // Producer side: drives flags and valid, observes tracker status.
  modport master (
    output in_valid,
    output a_eq_b,
    output a_ls_b,
    output a_gt_b,
    input  in_ready,
    input  eq_cnt,
    input  ls_cnt,
    input  gt_cnt,
    input  stable,
    input  stable_res,
    input  err
  );

  // Tracker side: consumes flags, reports counts and stability.
  modport slave (
    input  in_valid,
    input  a_eq_b,
    input  a_ls_b,
    input  a_gt_b,
    output in_ready,
    output eq_cnt,
    output ls_cnt,
    output gt_cnt,
    output stable,
    output stable_res,
    output err
  );

endinterface

// File: rtl/cmp_result_tracker.sv
// Result tracker for a 2-bit magnitude comparator. Counts accepted
// A==B / A<B / A>B outcomes with saturating counters, flags a result as
// stable once STABLE_N identical samples arrive back to back, and traps
// non-one-hot flag patterns in a sticky ERROR state that only clr or
// reset can leave.
module cmp_result_tracker #(
  parameter int CNT_W    = 8,
  parameter int STABLE_N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  cmp_result_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_STABLE = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  // Result codes shared by prev and stable_res: 00 none, 01 eq, 10 ls, 11 gt.
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_EQ   = 2'b01;
  localparam logic [1:0] RES_LS   = 2'b10;
  localparam logic [1:0] RES_GT   = 2'b11;

  localparam logic [7:0]       STABLE_RUN = 8'(STABLE_N);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_p1;
  logic [CNT_W-1:0] eq_cnt_p1;
  logic [CNT_W-1:0] ls_cnt_p1;
  logic [CNT_W-1:0] gt_cnt_p1;
  logic [7:0]       run_p1;
  logic [1:0]       prev_p1;
  logic             stable_p1;
  logic [1:0]       stable_res_p1;
  logic             err_p1;

  logic             vld_p0;
  logic [1:0]       res_p0;
  logic             legal_p0;
  logic [7:0]       run_nxt_p0;
  logic             go_stable_p0;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  // Run-length increment capped at the stability threshold so a long
  // stable stretch never overflows the run counter.
  function automatic logic [7:0] run_inc(input logic [7:0] run);
    return (run >= STABLE_RUN) ? STABLE_RUN : run + 8'd1;
  endfunction

  // ---- p0: decode incoming flags and handshake ----

  // ERROR is the only state that refuses samples.
  assign bus.in_ready = (state_p1 != S_ERROR);
  assign vld_p0       = bus.in_valid && bus.in_ready;

  // One-hot flags map to a result code; anything else decodes to none.
  always_comb begin
    res_p0 = RES_NONE;
    unique case ({bus.a_eq_b, bus.a_ls_b, bus.a_gt_b})
      3'b100:  res_p0 = RES_EQ;
      3'b010:  res_p0 = RES_LS;
      3'b001:  res_p0 = RES_GT;
      default: res_p0 = RES_NONE;
    endcase
  end

  assign legal_p0 = (res_p0 != RES_NONE);

  // Run length after a legal accept: restarts on a new result or from IDLE.
  always_comb begin
    run_nxt_p0 = 8'd1;
    if ((state_p1 != S_IDLE) && (res_p0 == prev_p1)) begin
      run_nxt_p0 = run_inc(run_p1);
    end
  end

  assign go_stable_p0 = (run_nxt_p0 >= STABLE_RUN);

  // ---- p1: registered state, counts and status ----

  // Tracker FSM with registered counts and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1      <= S_IDLE;
      eq_cnt_p1     <= '0;
      ls_cnt_p1     <= '0;
      gt_cnt_p1     <= '0;
      run_p1        <= '0;
      prev_p1       <= RES_NONE;
      stable_p1     <= 1'b0;
      stable_res_p1 <= RES_NONE;
      err_p1        <= 1'b0;
    end else if (clr) begin
      // clr wins over a same-cycle accept; the sample is discarded.
      state_p1      <= S_IDLE;
      eq_cnt_p1     <= '0;
      ls_cnt_p1     <= '0;
      gt_cnt_p1     <= '0;
      run_p1        <= '0;
      prev_p1       <= RES_NONE;
      stable_p1     <= 1'b0;
      stable_res_p1 <= RES_NONE;
      err_p1        <= 1'b0;
    end else if (vld_p0) begin
      if (!legal_p0) begin
        // Illegal flags freeze counts, run and prev until clr.
        state_p1      <= S_ERROR;
        err_p1        <= 1'b1;
        stable_p1     <= 1'b0;
        stable_res_p1 <= RES_NONE;
      end else begin
        unique case (res_p0)
          RES_EQ:  eq_cnt_p1 <= sat_inc(eq_cnt_p1);
          RES_LS:  ls_cnt_p1 <= sat_inc(ls_cnt_p1);
          default: gt_cnt_p1 <= sat_inc(gt_cnt_p1);
        endcase
        run_p1  <= run_nxt_p0;
        prev_p1 <= res_p0;
        if (go_stable_p0) begin
          state_p1      <= S_STABLE;
          stable_p1     <= 1'b1;
          stable_res_p1 <= res_p0;
        end else begin
          state_p1      <= S_TRACK;
          stable_p1     <= 1'b0;
          stable_res_p1 <= RES_NONE;
        end
      end
    end
  end

  assign bus.eq_cnt     = eq_cnt_p1;
  assign bus.ls_cnt     = ls_cnt_p1;
  assign bus.gt_cnt     = gt_cnt_p1;
  assign bus.stable     = stable_p1;
  assign bus.stable_res = stable_res_p1;
  assign bus.err        = err_p1;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed bench for cmp_result_tracker: a default instance (CNT_W=8,
// STABLE_N=4) and a narrow instance (CNT_W=2) for counter saturation.
module tb_cmp_result_tracker;

  logic clk;
  logic rst_n;
  logic clr;
  int   checks;
  int   failures;

  cmp_result_tracker_if #(.CNT_W(8)) ifa ();
  cmp_result_tracker_if #(.CNT_W(2)) ifb ();

  cmp_result_tracker #(.CNT_W(8), .STABLE_N(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (ifa)
  );

  cmp_result_tracker #(.CNT_W(2), .STABLE_N(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accept attempt on instance A; returns 1 time unit after the edge.
  task automatic acc_a(input logic e, input logic l, input logic g);
    ifa.in_valid = 1'b1;
    ifa.a_eq_b = e; ifa.a_ls_b = l; ifa.a_gt_b = g;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.a_eq_b = 1'b0; ifa.a_ls_b = 1'b0; ifa.a_gt_b = 1'b0;
  endtask

  task automatic acc_b(input logic e, input logic l, input logic g);
    ifb.in_valid = 1'b1;
    ifb.a_eq_b = e; ifb.a_ls_b = l; ifb.a_gt_b = g;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    ifb.a_eq_b = 1'b0; ifb.a_ls_b = 1'b0; ifb.a_gt_b = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clr = 1'b0;
    ifa.in_valid = 1'b0; ifa.a_eq_b = 1'b0; ifa.a_ls_b = 1'b0; ifa.a_gt_b = 1'b0;
    ifb.in_valid = 1'b0; ifb.a_eq_b = 1'b0; ifb.a_ls_b = 1'b0; ifb.a_gt_b = 1'b0;
    rst_n = 1'b0;
    #1;
    // Reset state
    check("rst_eq_cnt", ifa.eq_cnt, 0);
    check("rst_stable", ifa.stable, 0);
    check("rst_err", ifa.err, 0);
    check("rst_in_ready", ifa.in_ready, 1);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: four eq accepts reach stable eq
    acc_a(1, 0, 0); acc_a(1, 0, 0); acc_a(1, 0, 0);
    check("t1_eq3_cnt", ifa.eq_cnt, 3);
    check("t1_eq3_stable", ifa.stable, 0);
    check("t1_eq3_res", ifa.stable_res, 0);
    acc_a(1, 0, 0);
    check("t1_eq4_cnt", ifa.eq_cnt, 4);
    check("t1_eq4_stable", ifa.stable, 1);
    check("t1_eq4_res", ifa.stable_res, 2'b01);
    // Idle cycle changes nothing
    @(posedge clk); #1;
    check("t1_idle_cnt", ifa.eq_cnt, 4);
    check("t1_idle_stable", ifa.stable, 1);

    // 2: ls breaks stability, three more ls make it stable again
    acc_a(0, 1, 0);
    check("t2_ls1_stable", ifa.stable, 0);
    check("t2_ls1_cnt", ifa.ls_cnt, 1);
    check("t2_ls1_res", ifa.stable_res, 0);
    acc_a(0, 1, 0); acc_a(0, 1, 0);
    check("t2_ls3_stable", ifa.stable, 0);
    acc_a(0, 1, 0);
    check("t2_ls4_stable", ifa.stable, 1);
    check("t2_ls4_res", ifa.stable_res, 2'b10);
    check("t2_ls4_cnt", ifa.ls_cnt, 4);
    acc_a(0, 1, 0);
    check("t2_ls5_stable", ifa.stable, 1);
    check("t2_ls5_cnt", ifa.ls_cnt, 5);

    // 3: two flags set traps ERROR; counts frozen until clr
    acc_a(1, 1, 0);
    check("t3_err", ifa.err, 1);
    check("t3_in_ready", ifa.in_ready, 0);
    check("t3_stable", ifa.stable, 0);
    check("t3_eq_cnt", ifa.eq_cnt, 4);
    check("t3_ls_cnt", ifa.ls_cnt, 5);
    acc_a(1, 0, 0);
    check("t3_ignored_eq", ifa.eq_cnt, 4);
    check("t3_still_err", ifa.err, 1);
    pulse_clr();
    check("t3_clr_err", ifa.err, 0);
    check("t3_clr_eq", ifa.eq_cnt, 0);
    check("t3_clr_ls", ifa.ls_cnt, 0);
    check("t3_clr_ready", ifa.in_ready, 1);
    // No flags set is also illegal
    acc_a(0, 0, 0);
    check("t3_zero_err", ifa.err, 1);
    check("t3_zero_gt", ifa.gt_cnt, 0);
    pulse_clr();
    check("t3_zero_clr", ifa.err, 0);

    // Mismatch in TRACK restarts the run
    acc_a(1, 0, 0); acc_a(1, 0, 0); acc_a(0, 0, 1);
    check("tr_eq_cnt", ifa.eq_cnt, 2);
    check("tr_gt_cnt", ifa.gt_cnt, 1);
    acc_a(0, 0, 1); acc_a(0, 0, 1);
    check("tr_gt3_stable", ifa.stable, 0);
    acc_a(0, 0, 1);
    check("tr_gt4_stable", ifa.stable, 1);
    check("tr_gt4_res", ifa.stable_res, 2'b11);

    // 4: narrow counter saturates at 3
    acc_b(0, 0, 1); acc_b(0, 0, 1); acc_b(0, 0, 1);
    check("t4_gt3_cnt", ifb.gt_cnt, 3);
    check("t4_gt3_stable", ifb.stable, 0);
    acc_b(0, 0, 1);
    check("t4_gt4_cnt", ifb.gt_cnt, 3);
    check("t4_gt4_stable", ifb.stable, 1);
    acc_b(0, 0, 1);
    check("t4_gt5_cnt", ifb.gt_cnt, 3);
    check("t4_gt5_res", ifb.stable_res, 2'b11);

    // 5: clr beats a same-cycle accept
    pulse_clr();
    clr = 1'b1;
    acc_a(1, 0, 0);
    clr = 1'b0;
    check("t5_eq_cnt", ifa.eq_cnt, 0);
    check("t5_stable", ifa.stable, 0);
    acc_a(1, 0, 0);
    check("t5_after_eq", ifa.eq_cnt, 1);

    // 6: asynchronous reset mid-TRACK
    acc_a(1, 0, 0);
    check("t6_pre_eq", ifa.eq_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_eq", ifa.eq_cnt, 0);
    check("t6_async_stable", ifa.stable, 0);
    check("t6_async_ready", ifa.in_ready, 1);
    check("t6_async_b_gt", ifb.gt_cnt, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    acc_a(1, 0, 0);
    check("t6_post_eq", ifa.eq_cnt, 1);
    check("t6_post_stable", ifa.stable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
